nrzi_rx_deframer: RTL and testbench

- Receive end of the team's NRZI toggle line code. The transmit-side Moore FSM toggles its output level on every data '1'; this block recovers the bits from the line level, where a transition decodes to 1 and no transition decodes to 0.
- It also removes inserted (stuffed) '1' bits, hunts for a sync word, assembles fixed-length frames LSB-first into bytes, and delivers them over a valid/ready stream.
- It sits between the serial line sampler and the byte-oriented packet logic.

---
 rtl/nrzi_pkg.sv | 22 ++
 rtl/nrzi_destuff.sv | 59 +++++
 rtl/nrzi_rx_deframer.sv | 172 +++++++++++++++++
 tb/tb_nrzi_rx_deframer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nrzi_pkg.sv
// Shared constants for the NRZI receive path: state encoding, default framing
// parameters and the LSB-first shift helper used by the window and byte registers.
package nrzi_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned RUN_W           = 4;
    localparam int unsigned MAX_RUN_DEF     = 6;
    localparam int unsigned FRAME_BYTES_DEF = 4;

    localparam logic [BYTE_W-1:0] SYNC_WORD_DEF = 8'hD5;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HUNT = 2'b01;
    localparam logic [1:0] ST_DATA = 2'b10;

    // First bit received ends up in bit 0 after BYTE_W shifts.
    function automatic logic [BYTE_W-1:0] shift_lsb_first(input logic [BYTE_W-1:0] cur,
                                                          input logic              b);
        return {b, cur[BYTE_W-1:1]};
    endfunction

endpackage

// File: rtl/nrzi_destuff.sv
// NRZI toggle decode plus zero-run tracking; flags the stuffed '1' that must
// follow MAX_RUN zeros and reports a violation when a '0' arrives there instead.
module nrzi_destuff
    import nrzi_pkg::*;
#(
    parameter int unsigned MAX_RUN = MAX_RUN_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_en,
    input  logic line_in,
    input  logic destuff_en,
    output logic bit_vld,
    output logic bit_val,
    output logic stuff_viol
);

    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_RUN);

    logic             prev_line_q, prev_line_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             dec;

    always_comb begin
        dec         = line_in ^ prev_line_q;
        prev_line_d = bit_en ? line_in : prev_line_q;
        bit_vld     = bit_en;
        bit_val     = dec;
        stuff_viol  = 1'b0;
        run_d       = run_q;

        // Run count only matters inside a frame; holding it at zero elsewhere
        // means every frame starts with a clean count.
        if (!destuff_en) begin
            run_d = '0;
        end else if (bit_en) begin
            if (run_q == RUN_LIM) begin
                bit_vld    = 1'b0;
                stuff_viol = ~dec;
                run_d      = '0;
            end else if (dec) begin
                run_d = '0;
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_line_q <= 1'b0;
            run_q       <= '0;
        end else begin
            prev_line_q <= prev_line_d;
            run_q       <= run_d;
        end
    end

endmodule

// File: rtl/nrzi_rx_deframer.sv
// NRZI receive deframer: sync hunt, LSB-first byte assembly of fixed-length
// frames and a single-entry valid/ready output register.
module nrzi_rx_deframer
    import nrzi_pkg::*;
#(
    parameter logic [BYTE_W-1:0] SYNC_WORD   = SYNC_WORD_DEF,
    parameter int unsigned       MAX_RUN     = MAX_RUN_DEF,
    parameter int unsigned       FRAME_BYTES = FRAME_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bit_en,
    input  logic              line_in,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              frame_active,
    output logic              stuff_err,
    output logic              ovf_err,
    output logic [1:0]        state_dbg
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [BYTE_W-1:0] win_q, win_d;
    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [2:0]        bcnt_q, bcnt_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic [BYTE_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              stuff_err_q, stuff_err_d;
    logic              ovf_err_q, ovf_err_d;

    logic              bit_vld, bit_val, stuff_viol;
    logic              in_data;
    logic              byte_done, byte_last, can_load;
    logic [BYTE_W-1:0] win_next, sr_next;

    // Gating with en keeps a disable in DATA from raising a stuff violation.
    assign in_data = (state_q == ST_DATA) & en;

    nrzi_destuff #(
        .MAX_RUN(MAX_RUN)
    ) u_destuff (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .line_in   (line_in),
        .destuff_en(in_data),
        .bit_vld   (bit_vld),
        .bit_val   (bit_val),
        .stuff_viol(stuff_viol)
    );

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        sr_d        = sr_q;
        bcnt_d      = bcnt_q;
        fcnt_d      = fcnt_q;
        stuff_err_d = 1'b0;
        byte_done   = 1'b0;
        byte_last   = 1'b0;
        win_next    = shift_lsb_first(win_q, bit_val);
        sr_next     = shift_lsb_first(sr_q, bit_val);

        if (!en) begin
            state_d = ST_IDLE;
            win_d   = '0;
            sr_d    = '0;
            bcnt_d  = '0;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (bit_vld) begin
                        if (win_next == SYNC_WORD) begin
                            state_d = ST_DATA;
                            win_d   = '0;
                            sr_d    = '0;
                            bcnt_d  = '0;
                            fcnt_d  = '0;
                        end else begin
                            win_d = win_next;
                        end
                    end
                end
                ST_DATA: begin
                    if (stuff_viol) begin
                        stuff_err_d = 1'b1;
                        state_d     = ST_HUNT;
                        sr_d        = '0;
                        bcnt_d      = '0;
                        fcnt_d      = '0;
                    end else if (bit_vld) begin
                        sr_d   = sr_next;
                        bcnt_d = bcnt_q + 1'b1;
                        if (bcnt_q == 3'd7) begin
                            byte_done = 1'b1;
                            byte_last = (fcnt_q == LAST_IDX);
                            if (byte_last) begin
                                state_d = ST_HUNT;
                                fcnt_d  = '0;
                            end else begin
                                fcnt_d = fcnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Accept and reload may share a cycle; a full, unaccepted register drops the byte.
    always_comb begin
        can_load  = ~m_valid_q | m_ready;
        m_valid_d = m_valid_q & ~m_ready;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        ovf_err_d = 1'b0;
        if (byte_done) begin
            if (can_load) begin
                m_valid_d = 1'b1;
                m_data_d  = sr_next;
                m_last_d  = byte_last;
            end else begin
                ovf_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            win_q       <= '0;
            sr_q        <= '0;
            bcnt_q      <= '0;
            fcnt_q      <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            stuff_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            sr_q        <= sr_d;
            bcnt_q      <= bcnt_d;
            fcnt_q      <= fcnt_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            stuff_err_q <= stuff_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign stuff_err    = stuff_err_q;
    assign ovf_err      = ovf_err_q;
    assign frame_active = (state_q == ST_DATA);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_nrzi_rx_deframer.sv
// Bench for nrzi_rx_deframer: vector table for lock and first byte, directed
// corner sequences, then random frames against a frame-level reference model.
module tb_nrzi_rx_deframer;

    localparam int unsigned FB   = 4;
    localparam int unsigned MR   = 6;
    localparam logic [7:0]  SYNC = 8'hD5;

    logic       clk = 1'b0;
    logic       rst, en, bit_en, line_in, m_ready;
    logic [7:0] m_data;
    logic       m_valid, m_last, frame_active, stuff_err, ovf_err;
    logic [1:0] state_dbg;

    nrzi_rx_deframer #(
        .SYNC_WORD  (SYNC),
        .MAX_RUN    (MR),
        .FRAME_BYTES(FB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .bit_en      (bit_en),
        .line_in     (line_in),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_last      (m_last),
        .frame_active(frame_active),
        .stuff_err   (stuff_err),
        .ovf_err     (ovf_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic        line     = 1'b0;
    logic        rdy      = 1'b1;
    logic        rand_rdy = 1'b0;
    int unsigned gap_max  = 0;
    int unsigned tx_run   = 0;

    // Reference: one-entry output buffer plus expected error pulses.
    logic       mh     = 1'b0;
    logic [7:0] md     = 8'h00;
    logic       ml     = 1'b0;
    logic       eovf   = 1'b0;
    logic       estuff = 1'b0;

    typedef struct {
        logic       en;
        logic       be;
        logic       b;
        logic [1:0] st;
        logic       v;
        logic [7:0] d;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic e, input logic be, input logic b);
        en     = e;
        bit_en = be;
        if (be) line = line ^ b;
        line_in = line;
        m_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic mcyc(input logic e, input logic be, input logic b, input logic done,
                        input logic last, input logic viol, input logic [7:0] v);
        logic nh;
        if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
        chk("m_valid", 32'(m_valid), 32'(mh));
        if (mh) begin
            chk("m_data", 32'(m_data), 32'(md));
            chk("m_last", 32'(m_last), 32'(ml));
        end
        chk("ovf_err", 32'(ovf_err), 32'(eovf));
        chk("stuff_err", 32'(stuff_err), 32'(estuff));
        nh     = mh & ~rdy;
        eovf   = 1'b0;
        estuff = viol;
        if (done) begin
            if (!mh || rdy) begin
                nh = 1'b1;
                md = v;
                ml = last;
            end else begin
                eovf = 1'b1;
            end
        end
        mh = nh;
        drive(e, be, b);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic tx_bit(input logic b, input logic done, input logic last, input logic [7:0] v);
        mcyc(1'b1, 1'b1, b, done, last, 1'b0, v);
        if (gap_max > 0) idle($urandom_range(0, gap_max));
    endtask

    task automatic send_payload_bit(input logic b, input logic done, input logic last,
                                    input logic [7:0] v);
        tx_bit(b, done, last, v);
        if (b) tx_run = 0;
        else   tx_run++;
        if (tx_run == MR) begin
            tx_bit(1'b1, 1'b0, 1'b0, 8'h00);
            tx_run = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic last);
        for (int i = 0; i < 8; i++) send_payload_bit(v[i], (i == 7), last, v);
    endtask

    task automatic send_sync();
        logic [7:0] s;
        s = SYNC;
        for (int i = 0; i < 8; i++) tx_bit(s[i], 1'b0, 1'b0, 8'h00);
        tx_run = 0;
    endtask

    task automatic send_zeros(input int unsigned n);
        repeat (n) tx_bit(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [8*FB-1:0] p);
        send_sync();
        for (int b = 0; b < FB; b++) send_byte(p[8*b +: 8], (b == FB - 1));
        send_zeros(8);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Lock on 0xD5 then receive 0xA5, both LSB-first.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 8'hA5};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 8'hA5};

        rst = 1'b0; en = 1'b0; bit_en = 1'b0; line_in = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_active", 32'(frame_active), 32'd0);
        chk("rst_stuff", 32'(stuff_err), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].en, tbl[i].be, tbl[i].b);
            chk($sformatf("tbl%0d_state", i), 32'(state_dbg), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_valid", i), 32'(m_valid), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_data", i), 32'(m_data), 32'(tbl[i].d));
        end
        chk("lock_active", 32'(frame_active), 32'd1);

        // Rest of the first frame; 0x81 needs a stuffed 1 after six zeros.
        tx_run = 0;
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h81, 1'b1);
        chk("frame_end_state", 32'(state_dbg), 32'd1);
        chk("frame_end_active", 32'(frame_active), 32'd0);
        idle(2);

        // Destuffed 0x00 payload byte.
        send_frame({8'h56, 8'h34, 8'h12, 8'h00});
        idle(2);

        // Stuff violation: seven decoded zeros in DATA.
        send_sync();
        send_zeros(6);
        mcyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("viol_state", 32'(state_dbg), 32'd1);
        chk("viol_pulse", 32'(stuff_err), 32'd1);
        idle(2);
        send_zeros(8);

        // Backpressure: second byte dropped while the first is held.
        rdy = 1'b0;
        send_sync();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        chk("bp_hold", 32'(m_data), 32'h11);
        chk("bp_ovf", 32'(ovf_err), 32'd1);
        rdy = 1'b1;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        send_zeros(8);
        idle(2);

        // Disable mid-frame with a byte held, line toggling while idle.
        rdy = 1'b0;
        send_sync();
        send_byte(8'h5A, 1'b0);
        send_payload_bit(1'b0, 1'b0, 1'b0, 8'h00);
        send_payload_bit(1'b1, 1'b0, 1'b0, 8'h00);
        send_payload_bit(1'b1, 1'b0, 1'b0, 8'h00);
        mcyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("dis_state", 32'(state_dbg), 32'd0);
        chk("dis_held", 32'(m_valid), 32'd1);
        chk("dis_active", 32'(frame_active), 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic rb;
            rb = 1'($urandom_range(0, 1));
            mcyc(1'b0, 1'b1, rb, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("dis_idle", 32'(state_dbg), 32'd0);
        mcyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("reen_state", 32'(state_dbg), 32'd1);
        send_zeros(2);
        tx_bit(1'b1, 1'b0, 1'b0, 8'h00);
        tx_bit(1'b1, 1'b0, 1'b0, 8'h00);
        tx_bit(1'b0, 1'b0, 1'b0, 8'h00);
        chk("no_relock", 32'(state_dbg), 32'd1);
        rdy = 1'b1;
        send_zeros(8);
        send_frame({8'hDE, 8'hAD, 8'hBE, 8'hEF});
        idle(3);

        // Random payloads, gaps and consumer stalls.
        rand_rdy = 1'b1;
        gap_max  = 2;
        for (int f = 0; f < 25; f++) send_frame(32'($urandom));
        rand_rdy = 1'b0;
        gap_max  = 0;
        rdy      = 1'b1;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
